// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param: the counter consumes the
// controls through the slave modport and drives count/status back to the master.
interface updown_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic             terminal_count;
  logic             wrap;
  logic             overflow;

  modport master (
    output enable, up_down, load, load_value,
    input  q, terminal_count, wrap, overflow
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output q, terminal_count, wrap, overflow
  );
endinterface

// File: rtl/updown_counter_param.sv
// Modulo-(MAX_COUNT+1) up/down counter with load, terminal-count decode, wrap pulse and sticky overflow.
// Define COUNTER_SATURATE_EN to hold at the end stops instead of wrapping.
module updown_counter_param #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic                  clock,
  input  logic                  clear_n,
  updown_counter_param_if.slave ctr
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_COUNT,
    OP_LOAD
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             overflow;
  } state_t;

  state_t           state_r;
  state_t           state_nx;
  op_e              op;
  logic             at_max;
  logic             at_zero;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] boundary_value;
  logic [WIDTH-1:0] count_next;

  assign at_max   = (state_r.q == MAX_COUNT);
  assign at_zero  = (state_r.q == ZERO);
  assign boundary = ctr.up_down ? at_max : at_zero;

  // A full-range counter cannot receive an out-of-range load, so the clamp compare is elided.
  generate
    if (MAX_COUNT == {WIDTH{1'b1}}) begin : g_no_clamp
      assign load_clamped = ctr.load_value;
    end else begin : g_clamp
      assign load_clamped = (ctr.load_value > MAX_COUNT) ? MAX_COUNT : ctr.load_value;
    end
  endgenerate

`ifdef COUNTER_SATURATE_EN
  assign boundary_value = ctr.up_down ? MAX_COUNT : ZERO;
`else
  assign boundary_value = ctr.up_down ? ZERO : MAX_COUNT;
`endif

  // Off the boundary the +/-1 step stays inside 0..MAX_COUNT, so no modulo is needed.
  assign count_next = boundary      ? boundary_value    :
                      ctr.up_down   ? state_r.q + 1'b1  :
                                      state_r.q - 1'b1;

  always_comb begin
    op = OP_HOLD;
    if (ctr.load) begin
      op = OP_LOAD;
    end else if (ctr.enable) begin
      op = OP_COUNT;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned, which would infer a latch.
    state_nx      = state_r;
    state_nx.wrap = 1'b0;
    case (op)
      OP_LOAD: begin
        state_nx.q        = load_clamped;
        state_nx.overflow = 1'b0;
      end
      OP_COUNT: begin
        state_nx.q = count_next;
        if (boundary) begin
          state_nx.wrap     = 1'b1;
          state_nx.overflow = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of process order.
    if (!clear_n) begin
      state_r <= '0;
    end else begin
      state_r <= state_nx;
    end
  end

  assign ctr.q              = state_r.q;
  assign ctr.wrap           = state_r.wrap;
  assign ctr.overflow       = state_r.overflow;
  assign ctr.terminal_count = boundary;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param at WIDTH=4, MAX_COUNT=9; expectations follow
// COUNTER_SATURATE_EN when the bench is built with it.
module tb_updown_counter_param;

  localparam int WIDTH = 4;
  localparam int MAXC  = 9;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock;
  logic clear_n;
  int   checks;
  int   errors;

  updown_counter_param_if #(.WIDTH(WIDTH)) ctr ();

  updown_counter_param #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(4'd9)
  ) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .ctr    (ctr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; ctr.load = 1'b0; ctr.enable = 1'b0; ctr.up_down = 1'b1; ctr.load_value = '0;
    step();
    checks++;
    if (ctr.q !== 4'd0 || ctr.wrap !== 1'b0 || ctr.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: q=%0d wrap=%b ovf=%b, required q=0 wrap=0 ovf=0", ctr.q, ctr.wrap, ctr.overflow);
    end
    checks++;
    if (ctr.terminal_count !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc: tc=%b, required 0", ctr.terminal_count);
    end
    clear_n = 1'b1; ctr.load = 1'b1; ctr.load_value = 4'd5;
    step();
    checks++;
    if (ctr.q !== 4'd5) begin
      errors++;
      $display("FAIL reset_preload: q=%0d, required 5", ctr.q);
    end
    clear_n = 1'b0; ctr.load = 1'b1; ctr.enable = 1'b1; ctr.load_value = 4'd7;
    step();
    checks++;
    if (ctr.q !== 4'd0 || ctr.wrap !== 1'b0 || ctr.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_load: q=%0d wrap=%b ovf=%b, required q=0 wrap=0 ovf=0", ctr.q, ctr.wrap, ctr.overflow);
    end
    clear_n = 1'b1; ctr.load = 1'b0; ctr.enable = 1'b0;
  endtask

  task automatic test_up_wrap();
    int exp_q;
    exp_q = 0;
    ctr.up_down = 1'b1; ctr.enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (ctr.terminal_count !== (exp_q == MAXC)) begin
        errors++;
        $display("FAIL up_tc step %0d: tc=%b, required %b", i, ctr.terminal_count, (exp_q == MAXC));
      end
      step();
      exp_q = (i == 10) ? (SAT ? MAXC : 0) : i;
      checks++;
      if (ctr.q !== WIDTH'(exp_q) || ctr.wrap !== (i == 10) || ctr.overflow !== (i == 10)) begin
        errors++;
        $display("FAIL up_count step %0d: q=%0d wrap=%b ovf=%b, required q=%0d wrap=%b ovf=%b",
                 i, ctr.q, ctr.wrap, ctr.overflow, exp_q, (i == 10), (i == 10));
      end
    end
    ctr.enable = 1'b0;
    step();
    checks++;
    if (ctr.wrap !== 1'b0 || ctr.overflow !== 1'b1 || ctr.q !== WIDTH'(exp_q)) begin
      errors++;
      $display("FAIL up_after_wrap: q=%0d wrap=%b ovf=%b, required q=%0d wrap=0 ovf=1", ctr.q, ctr.wrap, ctr.overflow, exp_q);
    end
  endtask

  task automatic test_down_wrap();
    ctr.load = 1'b1; ctr.enable = 1'b1; ctr.load_value = 4'd0; ctr.up_down = 1'b0;
    step();
    checks++;
    if (ctr.q !== 4'd0 || ctr.overflow !== 1'b0 || ctr.wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_load0: q=%0d wrap=%b ovf=%b, required q=0 wrap=0 ovf=0", ctr.q, ctr.wrap, ctr.overflow);
    end
    ctr.load = 1'b0;
    #1;
    checks++;
    if (ctr.terminal_count !== 1'b1) begin
      errors++;
      $display("FAIL down_tc_at0: tc=%b, required 1", ctr.terminal_count);
    end
    step();
    checks++;
    if (ctr.q !== (SAT ? 4'd0 : 4'd9) || ctr.wrap !== 1'b1 || ctr.overflow !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: q=%0d wrap=%b ovf=%b, required q=%0d wrap=1 ovf=1", ctr.q, ctr.wrap, ctr.overflow, SAT ? 0 : 9);
    end
    if (!SAT) begin
      step();
      checks++;
      if (ctr.q !== 4'd8 || ctr.wrap !== 1'b0 || ctr.overflow !== 1'b1) begin
        errors++;
        $display("FAIL down_after_wrap: q=%0d wrap=%b ovf=%b, required q=8 wrap=0 ovf=1", ctr.q, ctr.wrap, ctr.overflow);
      end
    end
    ctr.enable = 1'b0;
  endtask

  task automatic test_load_clamp();
    ctr.load = 1'b1; ctr.enable = 1'b1; ctr.up_down = 1'b1; ctr.load_value = 4'd14;
    step();
    checks++;
    if (ctr.q !== 4'd9 || ctr.overflow !== 1'b0 || ctr.wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: q=%0d wrap=%b ovf=%b, required q=9 wrap=0 ovf=0", ctr.q, ctr.wrap, ctr.overflow);
    end
    checks++;
    if (ctr.terminal_count !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp_tc: tc=%b, required 1", ctr.terminal_count);
    end
    ctr.load_value = 4'd3;
    step();
    checks++;
    if (ctr.q !== 4'd3) begin
      errors++;
      $display("FAIL load_3: q=%0d, required 3", ctr.q);
    end
    ctr.load = 1'b0; ctr.enable = 1'b0;
  endtask

  task automatic test_hold_flip();
    logic [WIDTH-1:0] exp_seq [4];
    exp_seq[0] = 4'd5; exp_seq[1] = 4'd4; exp_seq[2] = 4'd5; exp_seq[3] = 4'd4;
    ctr.load = 1'b1; ctr.load_value = 4'd4;
    step();
    ctr.load = 1'b0; ctr.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ctr.q !== 4'd4 || ctr.wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold %0d: q=%0d wrap=%b, required q=4 wrap=0", i, ctr.q, ctr.wrap);
      end
    end
    ctr.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctr.up_down = (i % 2 == 0);
      step();
      checks++;
      if (ctr.q !== exp_seq[i]) begin
        errors++;
        $display("FAIL flip %0d: q=%0d, required %0d", i, ctr.q, exp_seq[i]);
      end
    end
    ctr.enable = 1'b0;
  endtask

  task automatic test_terminal_count();
    ctr.load = 1'b1; ctr.load_value = 4'd0;
    step();
    ctr.load = 1'b0; ctr.enable = 1'b0; ctr.up_down = 1'b0;
    #1;
    checks++;
    if (ctr.terminal_count !== 1'b1) begin
      errors++;
      $display("FAIL tc_down_q0: tc=%b, required 1", ctr.terminal_count);
    end
    ctr.up_down = 1'b1;
    #1;
    checks++;
    if (ctr.terminal_count !== 1'b0) begin
      errors++;
      $display("FAIL tc_up_q0: tc=%b, required 0", ctr.terminal_count);
    end
  endtask

  task automatic test_back_to_back();
    ctr.load = 1'b1; ctr.load_value = 4'd6;
    step();
    ctr.load = 1'b0; ctr.enable = 1'b1; ctr.up_down = 1'b1;
    step();
    clear_n = 1'b0;
    step();
    checks++;
    if (ctr.q !== 4'd0 || ctr.wrap !== 1'b0 || ctr.overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_count: q=%0d wrap=%b ovf=%b, required q=0 wrap=0 ovf=0", ctr.q, ctr.wrap, ctr.overflow);
    end
    clear_n = 1'b1;
    step();
    checks++;
    if (ctr.q !== 4'd1) begin
      errors++;
      $display("FAIL first_count_after_clear: q=%0d, required 1", ctr.q);
    end
    ctr.enable = 1'b0;
  endtask

  task automatic test_saturate();
    ctr.load = 1'b1; ctr.load_value = 4'd9; ctr.up_down = 1'b1;
    step();
    ctr.load = 1'b0; ctr.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ctr.q !== 4'd9 || ctr.wrap !== 1'b1 || ctr.overflow !== 1'b1) begin
        errors++;
        $display("FAIL sat_up %0d: q=%0d wrap=%b ovf=%b, required q=9 wrap=1 ovf=1", i, ctr.q, ctr.wrap, ctr.overflow);
      end
    end
    ctr.load = 1'b1; ctr.load_value = 4'd0; ctr.up_down = 1'b0;
    step();
    ctr.load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (ctr.q !== 4'd0 || ctr.wrap !== 1'b1 || ctr.overflow !== 1'b1) begin
        errors++;
        $display("FAIL sat_down %0d: q=%0d wrap=%b ovf=%b, required q=0 wrap=1 ovf=1", i, ctr.q, ctr.wrap, ctr.overflow);
      end
    end
    ctr.enable = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_n = 1'b0;
    ctr.enable = 1'b0; ctr.up_down = 1'b1; ctr.load = 1'b0; ctr.load_value = '0;
    #2;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_hold_flip();
    test_terminal_count();
    test_back_to_back();
    if (SAT) test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
